// File: rtl/logic_loop_sequencer_pkg.sv
// Shared types and default sizing for the logical-operator loop sequencer.
package logic_ops_pkg;

  localparam int unsigned DEF_W1    = 3;
  localparam int unsigned DEF_W2    = 4;
  localparam int unsigned DEF_LIMIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    LOOP
  } seq_state_e;

endpackage

// File: rtl/logic_loop_sequencer_if.sv
// Request/operand and result/strobe bundle between stimulus source, sequencer and monitor.
interface logic_loop_sequencer_if
  import logic_ops_pkg::*;
#(
  parameter int unsigned W1 = DEF_W1,
  parameter int unsigned W2 = DEF_W2
);

  logic          start;
  logic [W1-1:0] val1;
  logic [W2-1:0] val2;
  logic          busy;
  logic          val1_zero;
  logic          val2_zero;
  logic          cond;
  logic          iter_valid;
  logic [W2-1:0] iter_val;
  logic [W2-1:0] iter_cnt;
  logic          done;

  modport master (
    output start, val1, val2,
    input  busy, val1_zero, val2_zero, cond, iter_valid, iter_val, iter_cnt, done
  );

  modport slave (
    input  start, val1, val2,
    output busy, val1_zero, val2_zero, cond, iter_valid, iter_val, iter_cnt, done
  );

endinterface

// File: rtl/logic_loop_sequencer_flag_eval.sv
// Combinational logical reductions of the two operands.
module logic_flag_eval
  import logic_ops_pkg::*;
#(
  parameter int unsigned W1 = DEF_W1,
  parameter int unsigned W2 = DEF_W2
) (
  input  logic [W1-1:0] val1,
  input  logic [W2-1:0] val2,
  output logic          val1_zero,
  output logic          val2_zero,
  output logic          cond
);

  always_comb begin
    val1_zero = (val1 == '0);
    val2_zero = (val2 == '0);
    cond      = (val1 != '0) && (val2 == '0);
  end

endmodule

// File: rtl/logic_loop_sequencer.sv
// Captures two operands, registers their logical flags, then counts from val2 up to LIMIT.
module logic_loop_sequencer
  import logic_ops_pkg::*;
#(
  parameter int unsigned W1    = DEF_W1,
  parameter int unsigned W2    = DEF_W2,
  parameter int unsigned LIMIT = DEF_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_loop_sequencer_if.slave bus
);

  if (LIMIT >= (1 << W2)) begin : g_limit_check
    $error("LIMIT must be below 2**W2");
  end

  localparam logic [W2-1:0] LIMIT_V = W2'(LIMIT);

  seq_state_e    state_q, state_d;
  logic [W1-1:0] v1_q, v1_d;
  logic [W2-1:0] v2_q, v2_d;
  logic [W2-1:0] cur_q, cur_d;
  logic          busy_q, busy_d;
  logic          f1_q, f1_d, f2_q, f2_d, cond_q, cond_d;
  logic          iv_q, iv_d;
  logic [W2-1:0] ival_q, ival_d;
  logic [W2-1:0] icnt_q, icnt_d;
  logic          done_q, done_d;
  logic          e_v1z, e_v2z, e_cond;

  logic_flag_eval #(.W1(W1), .W2(W2)) u_flag_eval (
    .val1      (v1_q),
    .val2      (v2_q),
    .val1_zero (e_v1z),
    .val2_zero (e_v2z),
    .cond      (e_cond)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = EVAL;
      EVAL:    state_d = LOOP;
      LOOP:    if (cur_q >= LIMIT_V) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; iter_valid and done are pulses.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    cur_d  = cur_q;
    busy_d = busy_q;
    f1_d   = f1_q;
    f2_d   = f2_q;
    cond_d = cond_q;
    iv_d   = 1'b0;
    ival_d = ival_q;
    icnt_d = icnt_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          v1_d   = bus.val1;
          v2_d   = bus.val2;
          icnt_d = '0;
          ival_d = '0;
          f1_d   = 1'b0;
          f2_d   = 1'b0;
          cond_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      EVAL: begin
        f1_d   = e_v1z;
        f2_d   = e_v2z;
        cond_d = e_cond;
        cur_d  = v2_q;
      end
      LOOP: begin
        if (cur_q < LIMIT_V) begin
          iv_d   = 1'b1;
          ival_d = cur_q;
          cur_d  = cur_q + W2'(1);
          icnt_d = icnt_q + W2'(1);
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= '0;
      v2_q   <= '0;
      cur_q  <= '0;
      busy_q <= 1'b0;
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      cond_q <= 1'b0;
      iv_q   <= 1'b0;
      ival_q <= '0;
      icnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      cur_q  <= cur_d;
      busy_q <= busy_d;
      f1_q   <= f1_d;
      f2_q   <= f2_d;
      cond_q <= cond_d;
      iv_q   <= iv_d;
      ival_q <= ival_d;
      icnt_q <= icnt_d;
      done_q <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.val1_zero  = f1_q;
  assign bus.val2_zero  = f2_q;
  assign bus.cond       = cond_q;
  assign bus.iter_valid = iv_q;
  assign bus.iter_val   = ival_q;
  assign bus.iter_cnt   = icnt_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_logic_loop_sequencer.sv
// Table-driven bench with an iteration scoreboard and hand-written multi-cycle sequences.
module tb_logic_loop_sequencer;
  import logic_ops_pkg::*;

  localparam int unsigned W1    = 3;
  localparam int unsigned W2    = 4;
  localparam int unsigned LIMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_loop_sequencer_if #(.W1(W1), .W2(W2)) bus ();

  logic_loop_sequencer #(.W1(W1), .W2(W2), .LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [W2-1:0] exp_iter[$];

  typedef struct {
    logic [W1-1:0] val1;
    logic [W2-1:0] val2;
    bit            v1z;
    bit            v2z;
    bit            cnd;
    int            n;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs_all();
    return int'({bus.busy, bus.val1_zero, bus.val2_zero, bus.cond, bus.iter_valid,
                 bus.iter_val, bus.iter_cnt, bus.done});
  endfunction

  // Every iteration strobe must match the next expected loop value.
  always @(negedge clk) begin
    if (!rst && bus.iter_valid) begin
      if (exp_iter.size() == 0) begin
        check("unexpected_iter", 1, 0);
      end else begin
        check("iter_val", int'(bus.iter_val), int'(exp_iter.pop_front()));
      end
    end
  end

  task automatic push_iters(input logic [W2-1:0] v2);
    for (int unsigned i = v2; i < LIMIT; i++) exp_iter.push_back(W2'(i));
  endtask

  // Waits for done; returns cycles since the negedge after the accepting edge.
  task automatic wait_done(input int start_cyc, output int cyc, output bit seen);
    cyc  = start_cyc;
    seen = 0;
    while (cyc < 40 && !seen) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1;
    end
    check("done_seen", int'(seen), 1);
    if (!seen) exp_iter.delete();
  endtask

  task automatic run(input vec_t v, input bit poke);
    int cyc;
    bit seen;
    bus.start = 1'b1;
    bus.val1  = v.val1;
    bus.val2  = v.val2;
    push_iters(v.val2);
    @(negedge clk);
    check("busy_after_start", int'(bus.busy), 1);
    bus.start = 1'b0;
    bus.val1  = ~v.val1;
    bus.val2  = ~v.val2;
    @(negedge clk);
    check("val1_zero", int'(bus.val1_zero), int'(v.v1z));
    check("val2_zero", int'(bus.val2_zero), int'(v.v2z));
    check("cond", int'(bus.cond), int'(v.cnd));
    if (poke) begin
      bus.start = 1'b1;
      bus.val1  = '0;
      bus.val2  = 4'd9;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(2, cyc, seen);
    end else begin
      wait_done(1, cyc, seen);
    end
    if (seen) begin
      check("latency", cyc, v.n + 2);
      check("iter_cnt", int'(bus.iter_cnt), v.n);
      check("busy_at_done", int'(bus.busy), 0);
      check("cond_held", int'(bus.cond), int'(v.cnd));
      check("iters_consumed", exp_iter.size(), 0);
      exp_iter.delete();
      @(negedge clk);
      check("done_pulse_end", int'(bus.done), 0);
      check("idle_after_done", int'(bus.busy), 0);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    vec_t v;
    vecs[0] = '{3'b111, 4'b0000, 0, 1, 1, 3};
    vecs[1] = '{3'b000, 4'b0000, 1, 1, 0, 3};
    vecs[2] = '{3'b101, 4'b0111, 0, 0, 0, 0};
    vecs[3] = '{3'b000, 4'b0010, 1, 0, 0, 1};
    vecs[4] = '{3'b011, 4'b0001, 0, 0, 0, 2};
    vecs[5] = '{3'b000, 4'b1111, 1, 0, 0, 0};
    vecs[6] = '{3'b010, 4'b0011, 0, 0, 0, 0};

    bus.start = 1'b0;
    bus.val1  = '0;
    bus.val2  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_all(), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run(vecs[i], 1'b0);

    // start pulse during LOOP must be ignored
    run(vecs[0], 1'b1);

    // start held high: re-accepted on the edge sampled while done is high
    bus.start = 1'b1;
    bus.val1  = 3'b001;
    bus.val2  = '0;
    push_iters('0);
    push_iters('0);
    @(negedge clk);
    wait_done(0, cyc, seen);
    if (seen) begin
      check("held_first_latency", cyc, 5);
      check("held_busy_low", int'(bus.busy), 0);
      @(negedge clk);
      bus.start = 1'b0;
      check("held_reaccept_busy", int'(bus.busy), 1);
      check("held_reaccept_done", int'(bus.done), 0);
      wait_done(0, cyc, seen);
      if (seen) begin
        check("held_second_latency", cyc, 5);
        check("held_iter_cnt", int'(bus.iter_cnt), 3);
        check("held_iters_consumed", exp_iter.size(), 0);
      end
    end
    bus.start = 1'b0;
    exp_iter.delete();
    repeat (2) @(negedge clk);

    // reset mid-run discards the run
    bus.start = 1'b1;
    bus.val1  = 3'b111;
    bus.val2  = '0;
    push_iters('0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", outs_all(), 0);
    exp_iter.delete();
    rst = 1'b0;
    v = vecs[0];
    run(v, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
